// File: rtl/swap_ctrl_if.sv
// Bus bundle between the swap sequencer, its host and the register file.
// The slave modport is the sequencer's view; the master modport is the
// combined host + register-file side that surrounds it.
interface swap_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
);

  // Host request side
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  busy;
  logic                  done;

  // Register-file side
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_data_w;
  logic [DATA_WIDTH-1:0] mem_data_r;

  modport master (
    output start,
    output addr_a,
    output addr_b,
    output host_we,
    output host_addr,
    output host_wdata,
    output mem_data_r,
    input  host_rdata,
    input  busy,
    input  done,
    input  mem_we,
    input  mem_addr_w,
    input  mem_addr_r,
    input  mem_data_w
  );

  modport slave (
    input  start,
    input  addr_a,
    input  addr_b,
    input  host_we,
    input  host_addr,
    input  host_wdata,
    input  mem_data_r,
    output host_rdata,
    output busy,
    output done,
    output mem_we,
    output mem_addr_w,
    output mem_addr_r,
    output mem_data_w
  );

endinterface

// File: rtl/swap_ctrl.sv
// Swap sequencer in front of a register file with one synchronous write port
// and one asynchronous read port. Idle: host accesses pass straight through.
// On start: read A, read B, write A, write B, then a one-cycle done pulse.
module swap_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  swap_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StRdB  = 3'd2;
  localparam logic [2:0] StWrA  = 3'd3;
  localparam logic [2:0] StWrB  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] reg_a_q, reg_a_d;
  logic [ADDR_WIDTH-1:0] reg_b_q, reg_b_d;
  logic [DATA_WIDTH-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_WIDTH-1:0] tmp_b_q, tmp_b_d;

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    tmp_a_d = tmp_a_q;
    tmp_b_d = tmp_b_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          reg_a_d = bus.addr_a;
          reg_b_d = bus.addr_b;
          // Swapping a location with itself is a no-op: skip straight to done.
          state_d = (bus.addr_a == bus.addr_b) ? StDone : StRdA;
        end
      end
      StRdA: begin
        tmp_a_d = bus.mem_data_r;
        state_d = StRdB;
      end
      StRdB: begin
        tmp_b_d = bus.mem_data_r;
        state_d = StWrA;
      end
      StWrA:   state_d = StWrB;
      StWrB:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      reg_a_q <= '0;
      reg_b_q <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end

  // Moore output decode; only IDLE looks at host inputs.
  always_comb begin
    bus.host_rdata = bus.mem_data_r;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr_w = reg_a_q;
    bus.mem_addr_r = reg_a_q;
    bus.mem_data_w = tmp_b_q;
    case (state_q)
      StIdle: begin
        bus.busy       = 1'b0;
        bus.mem_we     = bus.host_we;
        bus.mem_addr_w = bus.host_addr;
        bus.mem_addr_r = bus.host_addr;
        bus.mem_data_w = bus.host_wdata;
      end
      StRdA: bus.mem_addr_r = reg_a_q;
      StRdB: bus.mem_addr_r = reg_b_q;
      // Gate swap writes with rst_n so a reset landing here aborts the write
      // on that very edge instead of letting it commit.
      StWrA: bus.mem_we = rst_n;
      StWrB: begin
        bus.mem_we     = rst_n;
        bus.mem_addr_w = reg_b_q;
        bus.mem_data_w = tmp_a_q;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Sequencer-driven writes only ever come from the two write states.
  a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StIdle && bus.mem_we) |-> (state_q == StWrA || state_q == StWrB));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done);

endmodule

// File: tb/tb_swap_ctrl.sv
// Randomized self-checking bench for swap_ctrl. A behavioural register file
// sits under the DUT; a reference memory image plus a per-swap cycle budget
// define what the host should observe.
module tb_swap_ctrl;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  swap_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  swap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: synchronous write, asynchronous read.
  logic [DW-1:0] rf [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) rf[bus.mem_addr_w] <= bus.mem_data_w;
  end
  assign bus.mem_data_r = rf[bus.mem_addr_r];

  // Expected memory contents.
  logic [DW-1:0] ref_mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.host_we    = 1'b0;
    bus.addr_a     = '0;
    bus.addr_b     = '0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    idle_inputs();
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    #1;
    check("host_we_pass", 32'(bus.mem_we), 32'd1);
    ref_mem[a] = d;
  endtask

  task automatic host_read(input logic [AW-1:0] a);
    @(negedge clk);
    idle_inputs();
    bus.host_addr = a;
    #1;
    check("host_rdata", 32'(bus.host_rdata), 32'(ref_mem[a]));
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  // junk: 0 quiet, 1 directed ignored requests in cycle 2, 2 random noise.
  task automatic do_swap(input logic [AW-1:0] a, input logic [AW-1:0] b, input int junk,
                         input logic hw, input logic [AW-1:0] hw_addr,
                         input logic [DW-1:0] hw_data);
    int          n_cyc;
    logic [DW-1:0] t;
    @(negedge clk);
    idle_inputs();
    bus.start      = 1'b1;
    bus.addr_a     = a;
    bus.addr_b     = b;
    bus.host_we    = hw;
    bus.host_addr  = hw_addr;
    bus.host_wdata = hw_data;
    #1;
    check("start_busy", 32'(bus.busy), 32'd0);
    check("start_we", 32'(bus.mem_we), 32'(hw));
    // A host write on the start edge lands before the swap reads.
    if (hw) ref_mem[hw_addr] = hw_data;
    n_cyc = (a == b) ? 1 : 5;
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      idle_inputs();
      if (junk == 1 && k == 2) begin
        bus.start      = 1'b1;
        bus.addr_a     = 7'd1;
        bus.addr_b     = 7'd2;
        bus.host_we    = 1'b1;
        bus.host_addr  = 7'd5;
        bus.host_wdata = 8'h00;
      end else if (junk == 2) begin
        bus.start      = 1'($urandom);
        bus.addr_a     = AW'($urandom);
        bus.addr_b     = AW'($urandom);
        bus.host_we    = 1'($urandom);
        bus.host_addr  = AW'($urandom);
        bus.host_wdata = DW'($urandom);
      end
      #1;
      check($sformatf("busy_c%0d", k), 32'(bus.busy), 32'd1);
      check($sformatf("done_c%0d", k), 32'(bus.done), 32'(k == n_cyc));
      check($sformatf("we_c%0d", k), 32'(bus.mem_we), 32'(a != b && (k == 3 || k == 4)));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("back_idle_busy", 32'(bus.busy), 32'd0);
    check("back_idle_done", 32'(bus.done), 32'd0);
    t = ref_mem[a];
    ref_mem[a] = ref_mem[b];
    ref_mem[b] = t;
    host_read(a);
    host_read(b);
  endtask

  // Reset lands during the WR_B cycle: A already overwritten, B untouched.
  task automatic swap_reset_wrb(input logic [AW-1:0] a, input logic [AW-1:0] b);
    @(negedge clk);
    idle_inputs();
    bus.start  = 1'b1;
    bus.addr_a = a;
    bus.addr_b = b;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 4) rst_n = 1'b0;
      #1;
      check("rst_run_busy", 32'(bus.busy), 32'd1);
    end
    check("rst_wrb_we_gated", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    ref_mem[a] = ref_mem[b];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("rst_no_done", 32'(bus.done), 32'd0);
      check("rst_no_we", 32'(bus.mem_we), 32'd0);
    end
    host_read(a);
    host_read(b);
  endtask

  initial begin
    logic [AW-1:0] a, b, ha;
    logic [DW-1:0] d;
    int            op;
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_busy0", 32'(bus.busy), 32'd0);
    check("idle_we0", 32'(bus.mem_we), 32'd0);

    // Preload every location through the host path.
    for (int i = 0; i < int'(DEPTH); i++) host_write(AW'(i), DW'($urandom));

    // Directed cases.
    host_write(7'd3, 8'h11);
    host_read(7'd3);
    host_write(7'd5, 8'hAA);
    host_write(7'd9, 8'h55);
    do_swap(7'd5, 7'd9, 0, 1'b0, '0, '0);
    check("swap_5", 32'(ref_mem[5]), 32'h55);
    host_write(7'd7, 8'h3C);
    do_swap(7'd7, 7'd7, 0, 1'b0, '0, '0);
    host_write(7'd0, 8'h01);
    host_write(7'd127, 8'hFF);
    do_swap(7'd0, 7'd127, 0, 1'b0, '0, '0);
    do_swap(7'd0, 7'd127, 0, 1'b0, '0, '0);
    host_read(7'd0);
    do_swap(7'd20, 7'd40, 1, 1'b0, '0, '0);
    host_read(7'd5);
    host_read(7'd1);
    host_read(7'd2);
    // Host write coinciding with start: swap must see the new value.
    do_swap(7'd30, 7'd31, 0, 1'b1, 7'd30, 8'h5A);
    swap_reset_wrb(7'd50, 7'd60);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      a  = AW'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? a : AW'($urandom);
      d  = DW'($urandom);
      ha = $urandom_range(0, 1) ? a : AW'($urandom);
      case (op)
        0: host_write(a, d);
        1: host_read(a);
        2: do_swap(a, b, int'($urandom_range(0, 2)), 1'b0, '0, '0);
        default: do_swap(a, b, int'($urandom_range(0, 2)), 1'b1, ha, d);
      endcase
    end

    // Whole-memory sweep against the reference image.
    for (int i = 0; i < int'(DEPTH); i++) host_read(AW'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
